// File: rtl/ines_prg_loader.sv
// Streaming iNES loader: validates the header, programs PRG-ROM (mirroring 1-bank images),
// drops CHR, and holds the CPU in reset until done. Optional: INES_LOADER_TRAINER_SKIP_EN.
module ines_prg_loader #(
  parameter logic [15:0] PRG_BASE   = 16'h8000,
  parameter logic [15:0] MIRROR_OFS = 16'h4000
) (
  input  logic        ROM_CLK,
  input  logic        RESET,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        rom_prgmr_wren,
  output logic [15:0] rom_prgmr_addr,
  output logic [7:0]  rom_prgmr_data,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    HDR,
`ifdef INES_LOADER_TRAINER_SKIP_EN
    TRAIN,
`endif
    PRG,
    MIRR,
    CHR,
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d, prg_exit;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic        two_bank_q, two_bank_d;
  logic [7:0]  chr_banks_q, chr_banks_d;
  logic [14:0] ofs_q, ofs_d;
  logic [20:0] chr_cnt_q, chr_cnt_d, chr_last;
  logic        ready_q, ready_d;
  logic        wren_q, wren_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, err_q;
  logic [7:0]  magic;
  logic        xfer;
`ifdef INES_LOADER_TRAINER_SKIP_EN
  logic        trainer_q, trainer_d;
  logic [8:0]  trn_cnt_q, trn_cnt_d;
`endif

  assign xfer     = in_valid & ready_q;
  assign chr_last = {chr_banks_q, 13'd0} - 21'd1;
  assign prg_exit = (chr_banks_q != 8'd0) ? CHR : DONE;

  always_comb begin
    unique case (hdr_cnt_q[1:0])
      2'd0:    magic = 8'h4E;
      2'd1:    magic = 8'h45;
      2'd2:    magic = 8'h53;
      default: magic = 8'h1A;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    two_bank_d  = two_bank_q;
    chr_banks_d = chr_banks_q;
    ofs_d       = ofs_q;
    chr_cnt_d   = chr_cnt_q;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
`ifdef INES_LOADER_TRAINER_SKIP_EN
    trainer_d   = trainer_q;
    trn_cnt_d   = trn_cnt_q;
`endif
    case (state_q)
      HDR: if (xfer) begin
        hdr_cnt_d = hdr_cnt_q + 4'd1;
        case (hdr_cnt_q)
          4'd0, 4'd1, 4'd2, 4'd3: if (in_data != magic) state_d = ERR;
          4'd4: begin
            if (in_data != 8'd1 && in_data != 8'd2) state_d = ERR;
            two_bank_d = in_data[1];
          end
          4'd5: chr_banks_d = in_data;
`ifdef INES_LOADER_TRAINER_SKIP_EN
          4'd6: trainer_d = in_data[2];
          4'd15: state_d = trainer_q ? TRAIN : PRG;
`else
          4'd6: if (in_data[2]) state_d = ERR;
          4'd15: state_d = PRG;
`endif
          default: ;
        endcase
      end
`ifdef INES_LOADER_TRAINER_SKIP_EN
      TRAIN: if (xfer) begin
        trn_cnt_d = trn_cnt_q + 9'd1;
        if (trn_cnt_q == 9'h1FF) state_d = PRG;
      end
`endif
      PRG: if (xfer) begin
        wren_d = 1'b1;
        addr_d = PRG_BASE + {1'b0, ofs_q};
        data_d = in_data;
        // 1-bank images advance the offset only after the mirror write
        if (!two_bank_q) state_d = MIRR;
        else begin
          ofs_d = ofs_q + 15'd1;
          if (ofs_q == 15'h7FFF) state_d = prg_exit;
        end
      end
      MIRR: begin
        wren_d  = 1'b1;
        addr_d  = PRG_BASE + {1'b0, ofs_q} + MIRROR_OFS;
        ofs_d   = ofs_q + 15'd1;
        state_d = (ofs_q == 15'h3FFF) ? prg_exit : PRG;
      end
      CHR: if (xfer) begin
        chr_cnt_d = chr_cnt_q + 21'd1;
        if (chr_cnt_q == chr_last) state_d = DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_d = (state_d == HDR) || (state_d == PRG) || (state_d == CHR);
`ifdef INES_LOADER_TRAINER_SKIP_EN
    if (state_d == TRAIN) ready_d = 1'b1;
`endif
  end

  always_ff @(posedge ROM_CLK) begin
    if (RESET) begin
      state_q     <= HDR;
      hdr_cnt_q   <= '0;
      two_bank_q  <= 1'b0;
      chr_banks_q <= '0;
      ofs_q       <= '0;
      chr_cnt_q   <= '0;
      ready_q     <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef INES_LOADER_TRAINER_SKIP_EN
      trainer_q   <= 1'b0;
      trn_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      two_bank_q  <= two_bank_d;
      chr_banks_q <= chr_banks_d;
      ofs_q       <= ofs_d;
      chr_cnt_q   <= chr_cnt_d;
      ready_q     <= ready_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      // done lags DONE entry so the CPU leaves reset after the final write has landed
      done_q      <= (state_q == DONE);
      err_q       <= (state_d == ERR);
`ifdef INES_LOADER_TRAINER_SKIP_EN
      trainer_q   <= trainer_d;
      trn_cnt_q   <= trn_cnt_d;
`endif
    end
  end

  assign in_ready       = ready_q;
  assign rom_prgmr_wren = wren_q;
  assign rom_prgmr_addr = addr_q;
  assign rom_prgmr_data = data_q;
  assign cpu_reset_n    = done_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule

// File: doc/ines_prg_loader.md
# ines_prg_loader

Streaming iNES image loader sitting directly upstream of the cartridge ROM programmer port. Accepts a byte stream (UART/JTAG bridge) over a valid/ready handshake, validates the 16-byte iNES header, and writes PRG-ROM bytes into the cartridge via the `rom_prgmr_*` interface, mirroring 16 KiB images across the 32 KiB window. Holds the CPU in reset until the image is fully consumed, then releases it; CHR bytes are consumed and discarded.

## Interface
Parameters:
- `PRG_BASE`, 16'h8000: cartridge address of first PRG byte.
- `MIRROR_OFS`, 16'h4000: offset of the mirrored copy for 1-bank images.

Ports:
- `ROM_CLK`  in  1  single clock for the whole block.
- `RESET`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  block accepts `in_data` this cycle; transfer = `in_valid & in_ready`.
- `rom_prgmr_wren`  out  1  one-cycle write strobe to cartridge.
- `rom_prgmr_addr`  out  16  write address.
- `rom_prgmr_data`  out  8  write data.
- `cpu_reset_n`  out  1  drives CPU `RESET_n`; low while loading.
- `done`  out  1  image loaded, sticky until `RESET`.
- `error`  out  1  image rejected, sticky until `RESET`.

## Operation
- States: HDR, TRAIN, PRG, MIRR, CHR, DONE, ERR. Reset state HDR.
- HDR: count header bytes 0-15 (4-bit counter).
  - Bytes 0-3 must equal 8'h4E, 8'h45, 8'h53, 8'h1A; mismatch -> ERR on that transfer.
  - Byte 4 = PRG banks; must be 1 or 2, else -> ERR. Latched.
  - Byte 5 = CHR banks (8 KiB units), latched, any value.
  - Byte 6 bit 2 = trainer flag, latched (see Configuration).
  - Bytes 7-15 ignored. After byte 15: -> TRAIN if trainer, else -> PRG.
- TRAIN: consume and drop 512 bytes, then -> PRG.
- PRG: 15-bit offset counter from 0. Each transfer writes `PRG_BASE + offset`. Length 16384 x banks. 2 banks: writes sequential up to PRG_BASE+16'h7FFF. 1 bank: each transfer -> MIRR.
- MIRR: one write of the same byte to `PRG_BASE + offset + MIRROR_OFS`; `in_ready`=0; returns to PRG (or exits if last byte).
- After last PRG byte (and its mirror): -> CHR if CHR banks != 0, else -> DONE.
- CHR: 21-bit counter, consume 8192 x banks bytes, no writes; then -> DONE.
- DONE: `done`=1, `cpu_reset_n`=1, `in_ready`=0. Further input stalls.
- ERR: `error`=1, `cpu_reset_n`=0, `in_ready`=0. Exit only via `RESET`.
- Address arithmetic 16-bit, no carry out; offsets never exceed 16'h7FFF so no wrap.

## Timing
- Reset values (while `RESET`=1 and first cycle after): `in_ready`=0, `rom_prgmr_wren`=0, `rom_prgmr_addr`=16'h0000, `rom_prgmr_data`=8'h00, `cpu_reset_n`=0, `done`=0, `error`=0. `in_ready` rises the cycle after `RESET` deasserts.
- `in_ready` is a registered/state-derived output, never combinationally dependent on `in_valid`.
- Write latency: transfer at cycle N -> `rom_prgmr_wren`=1 with addr/data at cycle N+1, one cycle only.
- Mirror write at N+2; `in_ready`=0 at N+1, back to 1 at N+2 (max 1 transfer per 2 cycles for 1-bank images, 1 per cycle otherwise).
- `cpu_reset_n` rises in the same cycle `done` rises, which is no earlier than the cycle after the final PRG write strobe.
- `RESET` mid-load: aborts at next edge, all state/counters cleared, returns to HDR; a pending mirror write is dropped. Cartridge contents are not cleared.
- `in_valid` low: no state change, no writes.

## Configuration
- `INES_LOADER_TRAINER_SKIP_EN` defined: trainer flag set -> TRAIN state skips 512 bytes before PRG.
- Not defined: TRAIN state absent; trainer flag set -> ERR on header byte 6.

## Test plan
- 2-bank image, no trainer, CHR=1: 16 header + 32768 PRG + 8192 CHR -> 32768 strobes 16'h8000..16'hFFFF with matching data, `done`=1 and `cpu_reset_n`=1 after last CHR byte, `error`=0.
- 1-bank image, CHR=0, PRG byte k = k[7:0] -> each byte written to 16'h8000+k then 16'hC000+k on consecutive cycles, `in_ready` low on mirror cycles, 32768 strobes total.
- Header byte 2 = 8'h00 -> `error`=1 one cycle after that transfer, no strobes, `cpu_reset_n` stays 0; byte 4 = 3 -> same.
- Trainer flag set: with macro, 512 bytes 8'hEE then PRG -> no strobe carries 8'hEE, first write at 16'h8000; without macro -> `error`=1 after byte 6.
- `RESET` pulse after 1000 PRG bytes, then full valid image -> loads from header again, first strobe at 16'h8000, `done`=1 at end.
- Random `in_valid` gaps (~50% duty) on 2-bank image -> identical write sequence to gap-free run, no strobe while idle.
